// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read/write/reserve port bundle of the scoreboarded register file
interface reg_file_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   addrA;
   logic [AW-1:0]   addrB;
   logic [XLEN-1:0] dataA;
   logic [XLEN-1:0] dataB;
   logic            busyA;
   logic            busyB;
   logic            wr0_en;
   logic [AW-1:0]   wr0_addr;
   logic [XLEN-1:0] wr0_data;
   logic            wr1_en;
   logic [AW-1:0]   wr1_addr;
   logic [XLEN-1:0] wr1_data;
   logic            rsv_en;
   logic [AW-1:0]   rsv_addr;
   logic [AW:0]     busy_cnt;

   modport master (
      output addrA, addrB, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
      input  dataA, dataB, busyA, busyB, busy_cnt
   );

   modport slave (
      input  addrA, addrB, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
      output dataA, dataB, busyA, busyB, busy_cnt
   );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R/2W register file with per-register busy scoreboard
module reg_file_sb #(
   parameter int XLEN          = 32,
   parameter int AW            = 5,
   parameter bit BYPASS        = 1'b1,
   parameter bit HARDWIRE_ZERO = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   reg_file_sb_if.slave  rf
);
   localparam int NREG = 1 << AW;

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [AW:0]     busy_cnt_q;
   logic [AW:0]     busy_cnt_d;

   logic wr0_ok;
   logic wr1_ok;
   logic rsv_ok;

   // Register 0 swallows writes and reserves when it is hardwired.
   assign wr0_ok = rf.wr0_en && !(HARDWIRE_ZERO && (rf.wr0_addr == '0));
   assign wr1_ok = rf.wr1_en && !(HARDWIRE_ZERO && (rf.wr1_addr == '0));
   assign rsv_ok = rf.rsv_en && !(HARDWIRE_ZERO && (rf.rsv_addr == '0));

   // Reserve is applied last so a newer producer keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wr0_ok) busy_d[rf.wr0_addr] = 1'b0;
      if (wr1_ok) busy_d[rf.wr1_addr] = 1'b0;
      if (rsv_ok) busy_d[rf.rsv_addr] = 1'b1;
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (wr0_ok) regs_q[rf.wr0_addr] <= rf.wr0_data;
         if (wr1_ok) regs_q[rf.wr1_addr] <= rf.wr1_data;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   logic [AW-1:0]   rd_addr [2];
   logic [XLEN-1:0] rd_data [2];
   logic            rd_busy [2];

   assign rd_addr[0] = rf.addrA;
   assign rd_addr[1] = rf.addrB;

   // Port 1 outranks port 0 on the forward path, matching the commit order.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if (HARDWIRE_ZERO && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if (BYPASS && wr1_ok && (rf.wr1_addr == rd_addr[p])) begin
            rd_data[p] = rf.wr1_data;
            rd_busy[p] = 1'b0;
         end else if (BYPASS && wr0_ok && (rf.wr0_addr == rd_addr[p])) begin
            rd_data[p] = rf.wr0_data;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign rf.dataA    = rd_data[0];
   assign rf.dataB    = rd_data[1];
   assign rf.busyA    = rd_busy[0];
   assign rf.busyB    = rd_busy[1];
   assign rf.busy_cnt = busy_cnt_q;
endmodule
